ov5640_init_seq: RTL and testbench

Sequencer that walks the OV5640 RGB init register table and issues one SCCB register write per entry.
- Presents a table index and captures the 24-bit entry {reg_addr[15:0], data[7:0]}.
- Hands each write to the SCCB/I2C write engine and waits for completion.
- Inserts the power-up and software-reset settling delays.
- Retries NACKed writes and reports done or error to the capture pipeline.
- Sits between the init table ROM and the SCCB master.

---
 rtl/ov5640_init_seq.sv | 193 +++++++++++++++++++
 tb/tb_ov5640_init_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_init_seq.sv
// ov5640_init_seq
//   Walks the OV5640 init register table and issues one SCCB register write
//   per entry. It waits for the power-up delay, then for each index:
//   FETCH (ROM latency), LATCH, ISSUE (one-cycle wr_req) and WAIT_ACK.
//   NACKed writes are retried up to MAX_RETRY extra times. A write of 0x3008
//   with data bit7 set (sensor software reset) is followed by a settling delay.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-high reset; abandons any transfer
//   start        one-cycle pulse; starts/restarts from IDLE, DONE or ERROR
//   rom_addr     table index presented to a registered ROM
//   rom_q        table entry {reg_addr[15:0], data[7:0]}, one clock after rom_addr
//   wr_req       one-cycle write request to the SCCB master
//   wr_reg_addr  register address, stable from wr_req until wr_done
//   wr_data      register data, stable from wr_req until wr_done
//   wr_done      one-cycle completion pulse from the SCCB master
//   wr_nack      qualifies wr_done; 1 = slave did not acknowledge
//   busy         high in every state except IDLE, DONE and ERROR
//   init_done    level; whole table written successfully
//   init_err     level; retries exhausted on some entry
//   err_index    index of the failing entry while init_err is high
module ov5640_init_seq #(
  parameter int TABLE_LEN   = 252,
  parameter int ADDR_WIDTH  = 8,
  parameter int DELAY_WIDTH = 20,
  parameter int PWR_DELAY   = 1000000,
  parameter int SRST_DELAY  = 250000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [23:0]           rom_q,
  output logic                  wr_req,
  output logic [15:0]           wr_reg_addr,
  output logic [7:0]            wr_data,
  input  logic                  wr_done,
  input  logic                  wr_nack,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [ADDR_WIDTH-1:0] err_index
);

  localparam int RETRY_WIDTH = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0]  LAST_IDX   = ADDR_WIDTH'(TABLE_LEN - 1);
  localparam logic [RETRY_WIDTH-1:0] RETRY_MAX  = RETRY_WIDTH'(MAX_RETRY);
  // A zero delay maps to a single pass through the wait state.
  localparam bit                     PWR_NONE   = (PWR_DELAY == 0);
  localparam bit                     SRST_NONE  = (SRST_DELAY == 0);
  localparam logic [DELAY_WIDTH-1:0] PWR_LAST   = PWR_NONE  ? {DELAY_WIDTH{1'b0}}
                                                            : DELAY_WIDTH'(PWR_DELAY - 1);
  localparam logic [DELAY_WIDTH-1:0] SRST_LAST  = SRST_NONE ? {DELAY_WIDTH{1'b0}}
                                                            : DELAY_WIDTH'(SRST_DELAY - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PWR_WAIT  = 4'd1,
    S_FETCH     = 4'd2,
    S_LATCH     = 4'd3,
    S_ISSUE     = 4'd4,
    S_WAIT_ACK  = 4'd5,
    S_POST      = 4'd6,
    S_SRST_WAIT = 4'd7,
    S_DONE      = 4'd8,
    S_ERROR     = 4'd9
  } state_t;

  state_t                 state_r;
  logic [DELAY_WIDTH-1:0] cnt_r;
  logic [RETRY_WIDTH-1:0] retry_r;

  // True for the sensor software-reset command, which needs settling time.
  function automatic logic srst_hit(input logic [15:0] addr, input logic [7:0] data);
    return (addr == 16'h3008) && data[7];
  endfunction

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= {DELAY_WIDTH{1'b0}};
      retry_r     <= {RETRY_WIDTH{1'b0}};
      rom_addr    <= {ADDR_WIDTH{1'b0}};
      wr_req      <= 1'b0;
      wr_reg_addr <= 16'h0000;
      wr_data     <= 8'h00;
      busy        <= 1'b0;
      init_done   <= 1'b0;
      init_err    <= 1'b0;
      err_index   <= {ADDR_WIDTH{1'b0}};
    end else begin
      wr_req <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_r   <= S_PWR_WAIT;
            rom_addr  <= {ADDR_WIDTH{1'b0}};
            cnt_r     <= {DELAY_WIDTH{1'b0}};
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_index <= {ADDR_WIDTH{1'b0}};
            busy      <= 1'b1;
          end
        end

        S_PWR_WAIT: begin
          if (PWR_NONE || (cnt_r == PWR_LAST)) begin
            cnt_r   <= {DELAY_WIDTH{1'b0}};
            state_r <= S_FETCH;
          end else begin
            cnt_r <= cnt_r + DELAY_WIDTH'(1);
          end
        end

        // rom_addr is already stable; this cycle covers the ROM register.
        S_FETCH: begin
          state_r <= S_LATCH;
        end

        S_LATCH: begin
          wr_reg_addr <= rom_q[23:8];
          wr_data     <= rom_q[7:0];
          retry_r     <= {RETRY_WIDTH{1'b0}};
          wr_req      <= 1'b1;
          state_r     <= S_ISSUE;
        end

        // wr_req is high for this single cycle.
        S_ISSUE: begin
          state_r <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (wr_done) begin
            if (!wr_nack) begin
              state_r <= S_POST;
            end else if (retry_r != RETRY_MAX) begin
              // Re-issue the latched write; the ROM is not read again.
              retry_r <= retry_r + RETRY_WIDTH'(1);
              wr_req  <= 1'b1;
              state_r <= S_ISSUE;
            end else begin
              err_index <= rom_addr;
              init_err  <= 1'b1;
              busy      <= 1'b0;
              state_r   <= S_ERROR;
            end
          end
        end

        S_POST: begin
          if (srst_hit(wr_reg_addr, wr_data)) begin
            cnt_r   <= {DELAY_WIDTH{1'b0}};
            state_r <= S_SRST_WAIT;
          end else if (rom_addr == LAST_IDX) begin
            init_done <= 1'b1;
            busy      <= 1'b0;
            state_r   <= S_DONE;
          end else begin
            rom_addr <= rom_addr + ADDR_WIDTH'(1);
            state_r  <= S_FETCH;
          end
        end

        S_SRST_WAIT: begin
          if (SRST_NONE || (cnt_r == SRST_LAST)) begin
            cnt_r <= {DELAY_WIDTH{1'b0}};
            if (rom_addr == LAST_IDX) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state_r   <= S_DONE;
            end else begin
              rom_addr <= rom_addr + ADDR_WIDTH'(1);
              state_r  <= S_FETCH;
            end
          end else begin
            cnt_r <= cnt_r + DELAY_WIDTH'(1);
          end
        end

        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_init_seq.sv
`timescale 1ns/1ps
module tb_ov5640_init_seq;
  localparam int TL  = 8;
  localparam int AW  = 8;
  localparam int DW  = 20;
  localparam int PD  = 10;
  localparam int SD  = 50;
  localparam int MR  = 3;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_q;
  logic          wr_req;
  logic [15:0]   wr_reg_addr;
  logic [7:0]    wr_data;
  logic          wr_done;
  logic          wr_nack;
  logic          busy;
  logic          init_done;
  logic          init_err;
  logic [AW-1:0] err_index;

  logic m_done, m_nack;
  logic spur = 1'b0;
  assign wr_done = m_done | spur;
  assign wr_nack = m_nack;

  always #5 clk = ~clk;

  ov5640_init_seq #(
    .TABLE_LEN(TL), .ADDR_WIDTH(AW), .DELAY_WIDTH(DW),
    .PWR_DELAY(PD), .SRST_DELAY(SD), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .wr_req(wr_req), .wr_reg_addr(wr_reg_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_nack(wr_nack),
    .busy(busy), .init_done(init_done), .init_err(init_err), .err_index(err_index)
  );

  // Registered ROM model.
  logic [23:0] rom [TL];
  always @(posedge clk) rom_q <= rom[rom_addr[2:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int find_idx(input logic [23:0] w);
    for (int i = 0; i < TL; i++) if (rom[i] == w) return i;
    return -1;
  endfunction

  // SCCB master model: answers each wr_req after LAT cycles.
  int          nack_idx_g = -1;
  int          nack_n_g = 0;
  int          att_m;
  int          lat;
  logic        pend;
  logic [23:0] cur_w;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0; lat <= 0; m_done <= 1'b0; m_nack <= 1'b0; att_m <= 0; cur_w <= 24'h0;
    end else begin
      m_done <= 1'b0;
      m_nack <= 1'b0;
      if (start) att_m <= 0;
      if (wr_req) begin
        pend <= 1'b1; lat <= LAT; cur_w <= {wr_reg_addr, wr_data};
      end else if (pend) begin
        if (lat == 1) begin
          pend   <= 1'b0;
          m_done <= 1'b1;
          if (find_idx(cur_w) == nack_idx_g) begin
            att_m  <= att_m + 1;
            m_nack <= (att_m < nack_n_g);
          end
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  // Transaction log sampled on the falling edge.
  int          req_cyc[$];
  int          done_cyc[$];
  logic [23:0] req_w[$];
  always @(negedge clk) begin
    if (wr_req) begin
      req_cyc.push_back(cyc);
      req_w.push_back({wr_reg_addr, wr_data});
    end
    if (m_done) done_cyc.push_back(cyc);
  end

  int total = 0;
  int bad = 0;
  int start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic load_table(input bit srst1);
    rom[0] = 24'h3103_11;
    rom[1] = srst1 ? 24'h3008_82 : 24'h3008_42;
    rom[2] = 24'h3017_FF;
    rom[3] = 24'h3018_F3;
    rom[4] = 24'h3034_1A;
    rom[5] = 24'h3035_11;
    rom[6] = 24'h3036_46;
    rom[7] = 24'h3037_13;
  endtask

  // start is sampled on the edge that leaves start_cyc at the next falling edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(init_done || init_err) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", {31'd0, init_done | init_err}, 32'd1);
    @(negedge clk);
  endtask

  // Expected write stream from the table and the NACK plan; also checks timing.
  // First wr_req: 10 delay cycles + FETCH + LATCH -> 12 cycles after start.
  // done->next req: retry 1, normal 4 (POST,FETCH,LATCH,ISSUE), soft reset 4+50.
  task automatic check_log(input int br, input int bd, input int nidx, input int nn,
                           input int exp_nreq, input string tag);
    logic [23:0] exp_w[$];
    logic [23:0] w;
    int nact, a, g;
    for (int i = 0; i < TL; i++) begin
      a = (i == nidx) ? ((nn > MR) ? MR + 1 : nn + 1) : 1;
      for (int k = 0; k < a; k++) exp_w.push_back(rom[i]);
      if (i == nidx && nn > MR) break;
    end
    nact = req_w.size() - br;
    check({tag, "_nreq"}, nact, exp_nreq);
    if (nact > 0) check({tag, "_first_delay"}, req_cyc[br] - start_cyc, 12);
    for (int j = 0; j < exp_w.size() && j < nact; j++) begin
      check({tag, "_word"}, req_w[br + j], exp_w[j]);
      if (j + 1 < exp_w.size() && j + 1 < nact && bd + j < done_cyc.size()) begin
        w = exp_w[j];
        if (exp_w[j + 1] == w)                      g = 1;
        else if (w[23:8] == 16'h3008 && w[7])       g = 4 + SD;
        else                                        g = 4;
        check({tag, "_gap"}, req_cyc[br + j + 1] - done_cyc[bd + j], g);
      end
    end
  endtask

  typedef struct {
    bit srst1;
    int nack_idx;
    int nack_n;
    int exp_nreq;
    bit exp_done;
    bit exp_err;
    int exp_eidx;
    int exp_rom;
  } row_t;

  row_t rows[5];

  initial begin
    int br, bd, n;
    //          srst nidx nn nreq done err eidx rom
    rows[0] = '{1'b0, -1,  0,  8, 1'b1, 1'b0, 0, 7};  // plain pass, 3008_42 no delay
    rows[1] = '{1'b1, -1,  0,  8, 1'b1, 1'b0, 0, 7};  // soft-reset settling delay
    rows[2] = '{1'b0,  2,  2, 10, 1'b1, 1'b0, 0, 7};  // two NACKs then ACK
    rows[3] = '{1'b0,  5, 99,  9, 1'b0, 1'b1, 5, 5};  // retries exhausted
    rows[4] = '{1'b0, -1,  0,  8, 1'b1, 1'b0, 0, 7};  // restart from ERROR

    load_table(1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_req", {31'd0, wr_req}, 32'd0);
    check("rst_done", {31'd0, init_done}, 32'd0);
    check("rst_err", {31'd0, init_err}, 32'd0);
    check("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    check("rst_err_index", {24'd0, err_index}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 5; r++) begin
      load_table(rows[r].srst1);
      nack_idx_g = rows[r].nack_idx;
      nack_n_g   = rows[r].nack_n;
      br = req_w.size();
      bd = done_cyc.size();
      pulse_start();
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_clr_err", {31'd0, init_err}, 32'd0);
      check("start_clr_done", {31'd0, init_done}, 32'd0);
      check("start_clr_eidx", {24'd0, err_index}, 32'd0);
      wait_end();
      check("row_done", {31'd0, init_done}, {31'd0, rows[r].exp_done});
      check("row_err", {31'd0, init_err}, {31'd0, rows[r].exp_err});
      check("row_busy", {31'd0, busy}, 32'd0);
      check("row_err_index", {24'd0, err_index}, rows[r].exp_eidx);
      check("row_rom_addr", {24'd0, rom_addr}, rows[r].exp_rom);
      check_log(br, bd, rows[r].nack_idx, rows[r].nack_n, rows[r].exp_nreq, "row");
    end
    nack_idx_g = -1;
    nack_n_g   = 0;

    // Reset while waiting for the ack of index 3.
    load_table(1'b0);
    br = req_w.size();
    pulse_start();
    n = 0;
    while (req_w.size() - br < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    check("pre_rst_index", {24'd0, rom_addr}, 32'd3);
    reset = 1'b1;
    #1;
    check("async_wr_req", {31'd0, wr_req}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_rom_addr", {24'd0, rom_addr}, 32'd0);
    check("async_wr_addr", {16'd0, wr_reg_addr}, 32'd0);
    check("async_wr_data", {24'd0, wr_data}, 32'd0);
    check("async_done", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    br = req_w.size();
    repeat (30) @(negedge clk);
    check("idle_after_rst_reqs", req_w.size() - br, 32'd0);
    check("idle_after_rst_busy", {31'd0, busy}, 32'd0);
    bd = done_cyc.size();
    pulse_start();
    wait_end();
    check("rst_rerun_done", {31'd0, init_done}, 32'd1);
    check_log(br, bd, -1, 0, 8, "rerun");

    // start while busy and a spurious wr_done in FETCH are ignored.
    br = req_w.size();
    bd = done_cyc.size();
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // FETCH is sampled on the edge start_cyc+11.
    while (cyc < start_cyc + 10) @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    n = 0;
    while (req_w.size() - br < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end();
    check("ign_done", {31'd0, init_done}, 32'd1);
    check("ign_err", {31'd0, init_err}, 32'd0);
    check_log(br, bd, -1, 0, 8, "ignore");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
